// File: rtl/tri_raster_scan_if.sv
// Pixel output stream of the triangle rasteriser: valid/ready handshake carrying
// pixel coordinates and the inside flag.
interface tri_raster_scan_if #(
    parameter int W = 9
);
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_x;
    logic [W-1:0] out_y;
    logic         out_inside;

    modport master (output out_valid, output out_x, output out_y, output out_inside,
                    input  out_ready);
    modport slave  (input  out_valid, input  out_x, input  out_y, input  out_inside,
                    output out_ready);
endinterface

// File: rtl/tri_raster_scan.sv
// Triangle rasteriser: walks the screen-clipped bounding box in raster order and
// tests each pixel against three winding-normalised signed edge functions.
module tri_raster_scan #(
    parameter int W         = 9,
    parameter int SCREEN_W  = 320,
    parameter int SCREEN_H  = 240,
    parameter int INCLUSIVE = 1,
    parameter int EMIT_ALL  = 0
) (
    input  logic             CLOCK_50,
    input  logic             RST_N,
    input  logic             start,
    input  logic             abort,
    input  logic [W-1:0]     ax,
    input  logic [W-1:0]     ay,
    input  logic [W-1:0]     bx,
    input  logic [W-1:0]     by,
    input  logic [W-1:0]     cx,
    input  logic [W-1:0]     cy,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   inside_count,
    tri_raster_scan_if.master pix
);
    localparam int EW = 2*W + 3;
    localparam int PW = 2*W + 2;
    localparam logic [W-1:0] X_LIM = W'(SCREEN_W - 1);
    localparam logic [W-1:0] Y_LIM = W'(SCREEN_H - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SCAN  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [W-1:0] min3(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [W-1:0] max3(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Full-precision edge function: no intermediate truncation.
    function automatic logic signed [EW-1:0] edge_fn(
        input logic [W-1:0] x0, input logic [W-1:0] y0,
        input logic [W-1:0] x1, input logic [W-1:0] y1,
        input logic [W-1:0] px, input logic [W-1:0] py);
        logic signed [W:0]    dx, dy, qx, qy;
        logic signed [PW-1:0] p0, p1;
        dx = $signed({1'b0, x1}) - $signed({1'b0, x0});
        dy = $signed({1'b0, y1}) - $signed({1'b0, y0});
        qx = $signed({1'b0, px}) - $signed({1'b0, x0});
        qy = $signed({1'b0, py}) - $signed({1'b0, y0});
        p0 = PW'(dx) * PW'(qy);
        p1 = PW'(dy) * PW'(qx);
        return EW'(p0) - EW'(p1);
    endfunction

    state_t state_r, state_next;
    logic [W-1:0] ax_r, ay_r, bx_r, by_r, cx_r, cy_r;
    logic [W-1:0] xmin_r, xmax_r, ymax_r, x_r, y_r;
    logic         neg_r;
    logic [2*W-1:0] cnt_r, inside_count_r;
    logic         busy_r, done_r, out_valid_r, out_inside_r;
    logic [W-1:0] out_x_r, out_y_r;

    logic [W-1:0] x_lo_s, y_lo_s, x_hi_s, y_hi_s;
    logic signed [EW-1:0] area_s, e_ab_s, e_bc_s, e_ca_s, n_ab_s, n_bc_s, n_ca_s;
    logic empty_s, inside_s, free_s, fire_s, emit_s, last_s, abort_s;

    assign x_lo_s  = min3(ax_r, bx_r, cx_r);
    assign y_lo_s  = min3(ay_r, by_r, cy_r);
    assign x_hi_s  = (max3(ax_r, bx_r, cx_r) > X_LIM) ? X_LIM : max3(ax_r, bx_r, cx_r);
    assign y_hi_s  = (max3(ay_r, by_r, cy_r) > Y_LIM) ? Y_LIM : max3(ay_r, by_r, cy_r);
    assign area_s  = edge_fn(ax_r, ay_r, bx_r, by_r, cx_r, cy_r);
    assign empty_s = (area_s == '0) || (x_lo_s > X_LIM) || (y_lo_s > Y_LIM);

    assign e_ab_s = edge_fn(ax_r, ay_r, bx_r, by_r, x_r, y_r);
    assign e_bc_s = edge_fn(bx_r, by_r, cx_r, cy_r, x_r, y_r);
    assign e_ca_s = edge_fn(cx_r, cy_r, ax_r, ay_r, x_r, y_r);
    // Negating for clockwise triangles makes the test winding independent.
    assign n_ab_s = neg_r ? -e_ab_s : e_ab_s;
    assign n_bc_s = neg_r ? -e_bc_s : e_bc_s;
    assign n_ca_s = neg_r ? -e_ca_s : e_ca_s;
    assign inside_s = (INCLUSIVE != 0)
        ? (!n_ab_s[EW-1] && !n_bc_s[EW-1] && !n_ca_s[EW-1])
        : (!n_ab_s[EW-1] && !n_bc_s[EW-1] && !n_ca_s[EW-1] &&
           (n_ab_s != '0) && (n_bc_s != '0) && (n_ca_s != '0));

    assign abort_s = abort && (state_r != S_IDLE);
    assign free_s  = !out_valid_r || pix.out_ready;
    assign fire_s  = (state_r == S_SCAN) && free_s;
    assign emit_s  = inside_s || (EMIT_ALL != 0);
    assign last_s  = (x_r == xmax_r) && (y_r == ymax_r);

    // State register.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_next = state_r;
        if (abort_s) begin
            state_next = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE:  state_next = start ? S_SETUP : S_IDLE;
                S_SETUP: state_next = empty_s ? S_DONE : S_SCAN;
                S_SCAN:  state_next = (fire_s && last_s) ? S_DRAIN : S_SCAN;
                S_DRAIN: state_next = free_s ? S_DONE : S_DRAIN;
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Vertex/bbox capture, scan walk, output register and counters.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            ax_r <= '0; ay_r <= '0; bx_r <= '0; by_r <= '0; cx_r <= '0; cy_r <= '0;
            xmin_r <= '0; xmax_r <= '0; ymax_r <= '0;
            x_r <= '0; y_r <= '0; neg_r <= 1'b0;
            cnt_r <= '0; inside_count_r <= '0;
            busy_r <= 1'b0; done_r <= 1'b0;
            out_valid_r <= 1'b0; out_inside_r <= 1'b0; out_x_r <= '0; out_y_r <= '0;
        end else begin
            busy_r <= (state_next != S_IDLE);
            done_r <= (state_next == S_DONE);
            if ((state_r == S_IDLE) && start) begin
                ax_r <= ax; ay_r <= ay; bx_r <= bx; by_r <= by; cx_r <= cx; cy_r <= cy;
            end
            if (state_r == S_SETUP) begin
                xmin_r <= x_lo_s;
                xmax_r <= x_hi_s;
                ymax_r <= y_hi_s;
                x_r    <= x_lo_s;
                y_r    <= y_lo_s;
                neg_r  <= area_s[EW-1];
                cnt_r  <= '0;
            end
            if (abort_s) begin
                out_valid_r <= 1'b0;
            end else if (fire_s) begin
                out_valid_r <= emit_s;
                if (emit_s) begin
                    out_x_r      <= x_r;
                    out_y_r      <= y_r;
                    out_inside_r <= inside_s;
                end
                cnt_r <= cnt_r + (2*W)'(inside_s);
                if (x_r == xmax_r) begin
                    x_r <= xmin_r;
                    if (!last_s) begin
                        y_r <= y_r + W'(1);
                    end
                end else begin
                    x_r <= x_r + W'(1);
                end
            end else if ((state_r == S_DRAIN) && pix.out_ready) begin
                out_valid_r <= 1'b0;
            end
            // An empty job publishes zero: cnt_r is only cleared on this same edge.
            if (state_next == S_DONE) begin
                inside_count_r <= (state_r == S_SETUP) ? '0 : cnt_r;
            end
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign inside_count   = inside_count_r;
    assign pix.out_valid  = out_valid_r;
    assign pix.out_x      = out_x_r;
    assign pix.out_y      = out_y_r;
    assign pix.out_inside = out_inside_r;
endmodule

// File: tb/tb_tri_raster_scan.sv
// Bench for tri_raster_scan: three configurations (inclusive, strict, emit-all)
// driven with directed and random jobs, checked against a plain-arithmetic model.
module tb_tri_raster_scan;
    localparam int W  = 9;
    localparam int SW = 320;
    localparam int SH = 240;

    typedef logic [18:0] px_t;          // {inside, x, y}
    typedef px_t px_q_t[$];

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_n, abort, rdy;
    logic [2:0] start_v;
    logic [W-1:0] ax, ay, bx, by, cx, cy;
    logic [2:0] busy_v, done_v;
    logic [2*W-1:0] cnt_v [3];

    tri_raster_scan_if #(.W(W)) bus0 ();
    tri_raster_scan_if #(.W(W)) bus1 ();
    tri_raster_scan_if #(.W(W)) bus2 ();
    assign bus0.out_ready = rdy;
    assign bus1.out_ready = rdy;
    assign bus2.out_ready = rdy;

    tri_raster_scan #(.W(W), .SCREEN_W(SW), .SCREEN_H(SH), .INCLUSIVE(1), .EMIT_ALL(0)) u0 (
        .CLOCK_50(clk), .RST_N(rst_n), .start(start_v[0]), .abort(abort),
        .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
        .busy(busy_v[0]), .done(done_v[0]), .inside_count(cnt_v[0]), .pix(bus0));
    tri_raster_scan #(.W(W), .SCREEN_W(SW), .SCREEN_H(SH), .INCLUSIVE(0), .EMIT_ALL(0)) u1 (
        .CLOCK_50(clk), .RST_N(rst_n), .start(start_v[1]), .abort(abort),
        .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
        .busy(busy_v[1]), .done(done_v[1]), .inside_count(cnt_v[1]), .pix(bus1));
    tri_raster_scan #(.W(W), .SCREEN_W(SW), .SCREEN_H(SH), .INCLUSIVE(1), .EMIT_ALL(1)) u2 (
        .CLOCK_50(clk), .RST_N(rst_n), .start(start_v[2]), .abort(abort),
        .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
        .busy(busy_v[2]), .done(done_v[2]), .inside_count(cnt_v[2]), .pix(bus2));

    logic mon_valid [3];
    px_t  mon_px    [3];
    assign mon_valid[0] = bus0.out_valid;
    assign mon_valid[1] = bus1.out_valid;
    assign mon_valid[2] = bus2.out_valid;
    assign mon_px[0] = {bus0.out_inside, bus0.out_x, bus0.out_y};
    assign mon_px[1] = {bus1.out_inside, bus1.out_x, bus1.out_y};
    assign mon_px[2] = {bus2.out_inside, bus2.out_x, bus2.out_y};

    int n_pass = 0;
    int n_total = 0;

    px_q_t exp_q, got_q, ref_q;
    int exp_cnt, exp_n;
    int done_cnt, done_edge, first_valid_edge, stall_viol, oob;
    bit timed_out;
    logic ab_valid, ab_busy;

    function automatic int efn(int x0, int y0, int x1, int y1, int px, int py);
        return (x1 - x0) * (py - y0) - (y1 - y0) * (px - x0);
    endfunction

    // Index of first difference between two pixel streams, -1 if identical.
    function automatic int first_diff(px_q_t a, px_q_t b);
        int n;
        n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    // Reference: enumerate the clipped box and apply the inside rule directly.
    task automatic model(input int inc, input int ea, input int v[6]);
        int xmn, xmx, ymn, ymx, area, e0, e1, e2;
        bit ins;
        px_t ent;
        exp_q.delete(); exp_cnt = 0; exp_n = 0;
        xmn = v[0]; xmx = v[0]; ymn = v[1]; ymx = v[1];
        for (int k = 1; k < 3; k++) begin
            if (v[2*k] < xmn) xmn = v[2*k];
            if (v[2*k] > xmx) xmx = v[2*k];
            if (v[2*k+1] < ymn) ymn = v[2*k+1];
            if (v[2*k+1] > ymx) ymx = v[2*k+1];
        end
        if (xmx > SW - 1) xmx = SW - 1;
        if (ymx > SH - 1) ymx = SH - 1;
        area = efn(v[0], v[1], v[2], v[3], v[4], v[5]);
        if (area == 0 || xmn > xmx || ymn > ymx) return;
        for (int y = ymn; y <= ymx; y++) begin
            for (int x = xmn; x <= xmx; x++) begin
                exp_n++;
                e0 = efn(v[0], v[1], v[2], v[3], x, y);
                e1 = efn(v[2], v[3], v[4], v[5], x, y);
                e2 = efn(v[4], v[5], v[0], v[1], x, y);
                if (area < 0) begin e0 = -e0; e1 = -e1; e2 = -e2; end
                ins = inc ? (e0 >= 0 && e1 >= 0 && e2 >= 0) : (e0 > 0 && e1 > 0 && e2 > 0);
                if (ins) exp_cnt++;
                ent = {ins, 9'(x), 9'(y)};
                if (ins || ea) exp_q.push_back(ent);
            end
        end
    endtask

    // Drives one job and records what the DUT did; the tests judge the record.
    task automatic run_job(input int sel, input int v[6], input int stall_pct,
                           input int abort_after, input int tail);
        int edge_n, budget;
        bit hold_pend;
        px_t hold_val;
        model((sel == 1) ? 0 : 1, (sel == 2) ? 1 : 0, v);
        got_q.delete();
        done_cnt = 0; done_edge = -1; first_valid_edge = -1; stall_viol = 0; oob = 0;
        timed_out = 1'b0; ab_valid = 1'b1; ab_busy = 1'b1; hold_pend = 1'b0;
        budget = 50 + 6 * exp_n;
        ax = W'(v[0]); ay = W'(v[1]); bx = W'(v[2]); by = W'(v[3]); cx = W'(v[4]); cy = W'(v[5]);
        start_v = 3'b000;
        start_v[sel] = 1'b1;
        rdy = 1'b1;
        @(posedge clk); #1;
        start_v = 3'b000;
        edge_n = 1;
        forever begin
            if (hold_pend && (!mon_valid[sel] || mon_px[sel] !== hold_val)) stall_viol++;
            hold_pend = 1'b0;
            if (mon_valid[sel] && first_valid_edge < 0) first_valid_edge = edge_n;
            if (mon_valid[sel] && (mon_px[sel][17:9] >= 9'(SW) || mon_px[sel][8:0] >= 9'(SH))) oob++;
            if (done_v[sel]) begin
                done_cnt++; done_edge = edge_n;
                break;
            end
            if (abort_after > 0 && got_q.size() == abort_after) begin
                abort = 1'b1; rdy = 1'b0;
                @(posedge clk); #1;
                abort = 1'b0;
                ab_valid = mon_valid[sel];
                ab_busy = busy_v[sel];
                if (done_v[sel]) done_cnt++;
                break;
            end
            if (edge_n >= budget) begin
                timed_out = 1'b1;
                break;
            end
            rdy = ($urandom_range(99) >= stall_pct);
            if (mon_valid[sel] && rdy) got_q.push_back(mon_px[sel]);
            if (mon_valid[sel] && !rdy) begin hold_pend = 1'b1; hold_val = mon_px[sel]; end
            @(posedge clk); #1;
            edge_n++;
        end
        rdy = 1'b1;
        for (int i = 0; i < tail; i++) begin
            @(posedge clk); #1;
            if (done_v[sel]) done_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; abort = 1'b0; start_v = 3'b000; rdy = 1'b1;
        ax = '0; ay = '0; bx = '0; by = '0; cx = '0; cy = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            n_total++;
            if ({busy_v[s], done_v[s], mon_valid[s], mon_px[s], cnt_v[s]} !== 40'd0)
                $display("FAIL reset_state[%0d]: got busy=%b done=%b valid=%b px=%h cnt=%0d required all zero",
                         s, busy_v[s], done_v[s], mon_valid[s], mon_px[s], cnt_v[s]);
            else n_pass++;
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int d;
        run_job(0, '{0, 0, 4, 0, 0, 4}, 0, 0, 3);
        n_total++;
        if (timed_out !== 1'b0) $display("FAIL basic_timeout: job did not finish within budget");
        else n_pass++;
        d = first_diff(got_q, exp_q);
        n_total++;
        if (d != -1) $display("FAIL basic_stream: first difference at %0d (got %0d pixels, required %0d)", d, got_q.size(), exp_q.size());
        else n_pass++;
        n_total++;
        if (got_q.size() != 15) $display("FAIL basic_pixels: got %0d required 15", got_q.size());
        else n_pass++;
        n_total++;
        if (cnt_v[0] !== 18'd15) $display("FAIL basic_count: got %0d required 15", cnt_v[0]);
        else n_pass++;
        n_total++;
        if (done_cnt != 1) $display("FAIL basic_done_once: got %0d pulses required 1", done_cnt);
        else n_pass++;
        n_total++;
        if (first_valid_edge != 3) $display("FAIL basic_first_latency: got %0d required 3", first_valid_edge);
        else n_pass++;
        n_total++;
        if (done_edge != exp_n + 3) $display("FAIL basic_done_latency: got %0d required %0d", done_edge, exp_n + 3);
        else n_pass++;
        ref_q = got_q;
    endtask

    task automatic test_strict();
        px_q_t want;
        want = '{{1'b1, 9'd1, 9'd1}, {1'b1, 9'd2, 9'd1}, {1'b1, 9'd1, 9'd2}};
        run_job(1, '{0, 0, 4, 0, 0, 4}, 0, 0, 3);
        n_total++;
        if (first_diff(got_q, want) != -1) $display("FAIL strict_stream: got %0d pixels first=%h required 3 starting %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 19'd0, want[0]);
        else n_pass++;
        n_total++;
        if (cnt_v[1] !== 18'd3) $display("FAIL strict_count: got %0d required 3", cnt_v[1]);
        else n_pass++;
    endtask

    task automatic test_winding();
        run_job(0, '{0, 4, 4, 0, 0, 0}, 0, 0, 3);
        n_total++;
        if (first_diff(got_q, ref_q) != -1) $display("FAIL winding_stream: got %0d pixels required %0d identical to forward winding", got_q.size(), ref_q.size());
        else n_pass++;
        n_total++;
        if (cnt_v[0] !== 18'd15) $display("FAIL winding_count: got %0d required 15", cnt_v[0]);
        else n_pass++;
    endtask

    task automatic test_degenerate();
        run_job(0, '{0, 0, 2, 2, 4, 4}, 0, 0, 3);
        n_total++;
        if (first_valid_edge != -1) $display("FAIL degen_no_valid: out_valid seen at edge %0d required never", first_valid_edge);
        else n_pass++;
        n_total++;
        if (done_edge != 2) $display("FAIL degen_done_latency: got %0d required 2", done_edge);
        else n_pass++;
        n_total++;
        if (cnt_v[0] !== 18'd0 || done_cnt != 1) $display("FAIL degen_count: got cnt=%0d dones=%0d required 0 and 1", cnt_v[0], done_cnt);
        else n_pass++;
    endtask

    task automatic test_clip();
        run_job(0, '{300, 200, 511, 200, 300, 511}, 40, 0, 3);
        n_total++;
        if (first_diff(got_q, exp_q) != -1) $display("FAIL clip_stream: got %0d pixels required %0d", got_q.size(), exp_q.size());
        else n_pass++;
        n_total++;
        if (oob != 0) $display("FAIL clip_bounds: got %0d off-screen pixels required 0", oob);
        else n_pass++;
        n_total++;
        if (stall_viol != 0) $display("FAIL clip_stall_stable: got %0d changes under stall required 0", stall_viol);
        else n_pass++;
        n_total++;
        if (cnt_v[0] !== 18'(exp_cnt) || done_cnt != 1) $display("FAIL clip_count: got cnt=%0d dones=%0d required %0d and 1", cnt_v[0], done_cnt, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_emit_all();
        int flagged;
        run_job(2, '{0, 0, 4, 0, 0, 4}, 0, 0, 3);
        flagged = 0;
        foreach (got_q[i]) if (got_q[i][18]) flagged++;
        n_total++;
        if (got_q.size() != 25 || flagged != 15) $display("FAIL emit_all_pixels: got %0d pixels %0d inside required 25 and 15", got_q.size(), flagged);
        else n_pass++;
        n_total++;
        if (first_diff(got_q, exp_q) != -1) $display("FAIL emit_all_stream: first difference at %0d", first_diff(got_q, exp_q));
        else n_pass++;
        n_total++;
        if (cnt_v[2] !== 18'd15) $display("FAIL emit_all_count: got %0d required 15", cnt_v[2]);
        else n_pass++;
    endtask

    task automatic test_abort();
        px_q_t pre;
        run_job(2, '{0, 0, 4, 0, 0, 4}, 0, 10, 5);
        pre = exp_q[0:9];
        n_total++;
        if (first_diff(got_q, pre) != -1) $display("FAIL abort_prefix: got %0d pixels required first 10 of stream", got_q.size());
        else n_pass++;
        n_total++;
        if (ab_valid !== 1'b0 || ab_busy !== 1'b0) $display("FAIL abort_idle: got valid=%b busy=%b required 0 0", ab_valid, ab_busy);
        else n_pass++;
        n_total++;
        if (done_cnt != 0) $display("FAIL abort_no_done: got %0d pulses required 0", done_cnt);
        else n_pass++;
        n_total++;
        if (cnt_v[2] !== 18'd15) $display("FAIL abort_count_kept: got %0d required 15", cnt_v[2]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_job(0, '{0, 0, 4, 0, 0, 4}, 0, 0, 1);
        run_job(0, '{10, 3, 2, 9, 7, 12}, 0, 0, 3);
        n_total++;
        if (first_diff(got_q, exp_q) != -1 || done_edge != exp_n + 3) $display("FAIL b2b_second_job: got %0d pixels done at %0d required %0d pixels done at %0d", got_q.size(), done_edge, exp_q.size(), exp_n + 3);
        else n_pass++;
        n_total++;
        if (cnt_v[0] !== 18'(exp_cnt)) $display("FAIL b2b_count: got %0d required %0d", cnt_v[0], exp_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        int v[6];
        int sel, bxo, byo;
        for (int j = 0; j < 8; j++) begin
            sel = $urandom_range(2);
            bxo = ($urandom_range(1) == 1) ? 290 : 0;
            byo = ($urandom_range(1) == 1) ? 210 : 0;
            for (int k = 0; k < 3; k++) begin
                v[2*k]   = bxo + $urandom_range(40);
                v[2*k+1] = byo + $urandom_range(40);
            end
            run_job(sel, v, 25, 0, 3);
            n_total++;
            if (first_diff(got_q, exp_q) != -1 || stall_viol != 0 || timed_out)
                $display("FAIL random_stream[%0d]: dut %0d got %0d pixels stall_changes=%0d timeout=%b required %0d pixels",
                         j, sel, got_q.size(), stall_viol, timed_out, exp_q.size());
            else n_pass++;
            n_total++;
            if (cnt_v[sel] !== 18'(exp_cnt) || done_cnt != 1)
                $display("FAIL random_count[%0d]: dut %0d got cnt=%0d dones=%0d required %0d and 1", j, sel, cnt_v[sel], done_cnt, exp_cnt);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strict();
        test_winding();
        test_degenerate();
        test_clip();
        test_emit_all();
        test_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/tri_raster_scan.md
# tri_raster_scan

Parametrised triangle rasteriser that walks the screen-clipped bounding box of a triangle and, for each pixel, decides whether the point lies inside. The block uses signed edge functions, so the test does not depend on vertex winding. It sits between the vertex source and the frame-buffer writer. Pixels leave on a valid/ready stream, and a done pulse plus an inside-pixel count close each job.

## Interface
- W, 9: coordinate width (unsigned vertex coordinates).
- SCREEN_W, 320: horizontal clip limit; x ranges over 0..SCREEN_W-1.
- SCREEN_H, 240: vertical clip limit; y ranges over 0..SCREEN_H-1.
- INCLUSIVE, 1: 1 = pixels on an edge count as inside; 0 = strict interior only.
- EMIT_ALL, 0: 1 = emit every bbox pixel with its inside flag; 0 = emit inside pixels only.

Ports:
- CLOCK_50  in  1  system clock; one clock domain, all logic on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- start  in  1  job request; accepted only in IDLE.
- abort  in  1  synchronous cancel of the current job.
- ax, ay, bx, by, cx, cy  in  W each  triangle vertices; latched on the accepted start.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse at the end of a job.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  consumer accepts the pixel.
- out_x, out_y  out  W each  pixel coordinates.
- out_inside  out  1  inside flag; always 1 when EMIT_ALL=0.
- inside_count  out  2W  inside pixels in the last job; updated at done.

## Operation
- States: IDLE, SETUP, SCAN, DRAIN, DONE.
- IDLE:
  - start=1 latches all six vertices and moves to SETUP.
  - start in any other state is ignored.
- SETUP (1 cycle):
  - Bbox: xmin/xmax = min/max(ax,bx,cx); ymin/ymax likewise.
  - Clip the bbox to [0,SCREEN_W-1] and [0,SCREEN_H-1].
  - Compute area2 = E_ab(c).
  - If area2==0 or the clipped box is empty: go to DONE, emitting no pixels.
  - Otherwise: (x,y) = (xmin,ymin), clear the count, go to SCAN.
- Edge function:
  - E_ab(p) = (bx-ax)*(py-ay) - (by-ay)*(px-ax).
  - Differences are signed W+1 bits, products are signed 2W+2 bits, the result is signed 2W+3 bits. No truncation.
  - E_bc and E_ca are defined the same way.
- Normalisation: if area2<0, negate all three edge values before testing.
- Inside test:
  - INCLUSIVE=1: all three edge values ≥ 0.
  - INCLUSIVE=0: all three edge values > 0.
- SCAN:
  - Order is raster: x increments; at xmax, x returns to xmin and y increments.
  - When the output register is free (out_valid=0, or out_valid&out_ready), the current pixel is tested and (x,y) advances.
  - The pixel is loaded into the output register if it is inside, or if EMIT_ALL=1.
  - A non-emitted pixel still costs one cycle.
  - inside_count increments for each inside pixel.
  - After (xmax,ymax) is tested, go to DRAIN.
- DRAIN: wait until out_valid=0, or the final out_valid&out_ready handshake, then go to DONE.
- DONE (1 cycle): done=1, inside_count published, then IDLE.
- abort=1 in any non-IDLE state:
  - Next state is IDLE and out_valid drops.
  - No done pulse; inside_count is unchanged.
  - abort takes priority over start and over every other transition.
- Backpressure: while out_valid=1 and out_ready=0, out_x, out_y and out_inside hold stable and the scan stalls.

## Timing
- Reset values: state IDLE; busy=0, done=0, out_valid=0; out_x=0, out_y=0, out_inside=0; inside_count=0.
- Start at edge k: SETUP during cycle k+1, SCAN from k+2.
- The first pixel tested at the end of cycle k+2 appears with out_valid=1 at edge k+3, if emitted.
- Throughput: one pixel tested per cycle when out_ready=1.
- Scan length: exactly (xmax-xmin+1)*(ymax-ymin+1) tested pixels, plus stall cycles.
- done: asserted the cycle after the last handshake completes, or the cycle after SETUP for an empty or degenerate job.
- A new start is accepted in the IDLE cycle immediately after done.

## Test plan
- (0,0),(4,0),(0,4), INCLUSIVE=1, out_ready=1 -> exactly the 15 pixels with x+y≤4, in raster order; inside_count=15; done once.
- Same triangle, INCLUSIVE=0 -> exactly (1,1), (2,1), (1,2), in that order; inside_count=3.
- Vertices reversed, (0,4),(4,0),(0,0) -> identical pixel stream to the first scenario (winding independence).
- Degenerate (0,0),(2,2),(4,4) -> no out_valid; done 2 cycles after start; inside_count=0.
- Vertices (300,200),(511,200),(300,511), SCREEN 320x240 -> every out_x<320 and out_y<240; out_x/out_y/out_inside stable during random out_ready=0 stalls; count matches the reference model.
- EMIT_ALL=1 on the first triangle -> 25 pixels, with 15 flagged inside.
- EMIT_ALL=1 with abort after the 10th handshake -> out_valid=0 next cycle, no done, busy=0, inside_count unchanged.
